// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RISC-V load or store at a time, checks the
// funct3 and the alignment, runs a single request/grant/rvalid memory
// handshake with a timeout, and returns an extended load result.
module load_store_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_misaligned,
    output logic              rsp_fault,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_cnt;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata;
    logic              r_mis;
    logic              r_fault;

    logic              w_legal;
    logic              w_mis;
    logic              w_timeout;
    logic [XLEN-1:0]   w_shift;
    logic [XLEN-1:0]   w_ext;
    logic [NB-1:0]     w_be_base;
    logic [OFFW+2:0]   w_bit_off;

    assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));
    assign w_bit_off = {r_addr[OFFW-1:0], 3'b000};

    // Legality and alignment of the request presented this cycle
    always_comb begin
        w_legal = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                3'b011:                 w_legal = (XLEN == 64);
                default:                w_legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                3'b011, 3'b110:                         w_legal = (XLEN == 64);
                default:                                w_legal = 1'b0;
            endcase
        end
        case (req_funct3[1:0])
            2'b00:   w_mis = 1'b0;
            2'b01:   w_mis = req_addr[0];
            2'b10:   w_mis = |req_addr[1:0];
            default: w_mis = |req_addr[2:0];
        endcase
    end

    // Next-state decode; an arriving gnt/rvalid wins over an expiring timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_next = (!w_legal || w_mis) ? S_RESP : S_REQ;
            S_REQ: begin
                if (mem_gnt)        w_next = r_we ? S_RESP : S_WAIT;
                else if (w_timeout) w_next = S_RESP;
            end
            S_WAIT: if (mem_rvalid || w_timeout) w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // Load data alignment/extension and store byte-lane placement
    always_comb begin
        w_shift = mem_rdata >> w_bit_off;
        case (r_funct3)
            3'b000:  w_ext = XLEN'($signed(w_shift[7:0]));
            3'b001:  w_ext = XLEN'($signed(w_shift[15:0]));
            3'b010:  w_ext = XLEN'($signed(w_shift[31:0]));
            3'b100:  w_ext = XLEN'(w_shift[7:0]);
            3'b101:  w_ext = XLEN'(w_shift[15:0]);
            3'b110:  w_ext = XLEN'(w_shift[31:0]);
            default: w_ext = w_shift;
        endcase
        case (r_funct3[1:0])
            2'b00:   w_be_base = NB'(1);
            2'b01:   w_be_base = NB'(3);
            2'b10:   w_be_base = NB'(15);
            default: w_be_base = '1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Timeout counter: cleared on any state change, counts cycles in REQ/WAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                   r_cnt <= '0;
        else if (w_next != r_state)                     r_cnt <= '0;
        else if (r_state == S_REQ || r_state == S_WAIT) r_cnt <= r_cnt + 8'd1;
    end

    // Request capture on acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    // Completion status and load result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_mis   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_rdata <= '0;
                    r_fault <= !w_legal;
                    r_mis   <= w_legal && w_mis;
                end
                S_REQ:  if (!mem_gnt && w_timeout) r_fault <= 1'b1;
                S_WAIT: begin
                    if (mem_rvalid)     r_rdata <= w_ext;
                    else if (w_timeout) r_fault <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready      = (r_state == S_IDLE);
    assign rsp_valid      = (r_state == S_RESP);
    assign rsp_rdata      = rsp_valid ? r_rdata : '0;
    assign rsp_misaligned = rsp_valid && r_mis;
    assign rsp_fault      = rsp_valid && r_fault;
    assign mem_req        = (r_state == S_REQ);
    assign mem_we         = mem_req && r_we;
    assign mem_addr       = r_addr & ~XLEN'(NB - 1);
    assign mem_be         = (mem_req && r_we) ? (w_be_base << r_addr[OFFW-1:0]) : '0;
    assign mem_wdata      = r_wdata << w_bit_off;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: a 32-bit unit with a short timeout and a 64-bit unit.
module tb_load_store_unit;

  int total = 0;
  int bad   = 0;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance, TIMEOUT = 4
  logic        a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0;
  logic [2:0]  a_funct3 = '0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        a_rsp_valid, a_mis, a_fault, a_mem_req, a_mem_we;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        a_gnt = 1'b0, a_rvalid = 1'b0;
  logic [31:0] a_rdata = '0;

  // 64-bit instance, default TIMEOUT
  logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0;
  logic [2:0]  b_funct3 = '0;
  logic [63:0] b_addr = '0, b_wdata = '0;
  logic        b_rsp_valid, b_mis, b_fault, b_mem_req, b_mem_we;
  logic [63:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
  logic [7:0]  b_mem_be;
  logic        b_gnt = 1'b0, b_rvalid = 1'b0;
  logic [63:0] b_rdata = '0;

  load_store_unit #(.XLEN(32), .TIMEOUT(4)) u_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_funct3(a_funct3), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .rsp_misaligned(a_mis), .rsp_fault(a_fault),
    .mem_req(a_mem_req), .mem_gnt(a_gnt), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
    .mem_rvalid(a_rvalid), .mem_rdata(a_rdata)
  );

  load_store_unit #(.XLEN(64), .TIMEOUT(16)) u_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_funct3), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_misaligned(b_mis), .rsp_fault(b_fault),
    .mem_req(b_mem_req), .mem_gnt(b_gnt), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
    .mem_rvalid(b_rvalid), .mem_rdata(b_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns 1 ns after the accepting edge
  task automatic a_issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    a_req_valid = 1'b1; a_req_we = we; a_funct3 = f3; a_addr = addr; a_wdata = wd;
    tick();
    a_req_valid = 1'b0;
  endtask

  task automatic b_issue(input logic we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd);
    b_req_valid = 1'b1; b_req_we = we; b_funct3 = f3; b_addr = addr; b_wdata = wd;
    tick();
    b_req_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    #3;
    chk("rst_ready", a_req_ready, 1'b1);
    chk("rst_rsp_valid", a_rsp_valid, 1'b0);
    chk("rst_mem_req", a_mem_req, 1'b0);
    chk("rst_mem_we", a_mem_we, 1'b0);
    chk("rst_mem_be", a_mem_be, 4'h0);
    chk("rst_mem_addr", a_mem_addr, 32'h0);
    chk("rst_mem_wdata", a_mem_wdata, 32'h0);
    chk("rst_rdata", a_rsp_rdata, 32'h0);
    chk("rst_flags", {a_mis, a_fault}, 2'b00);
    chk("rst_b_ready", b_req_ready, 1'b1);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // lb at 0x1003, immediate gnt and rvalid: sign-extended 0x80
    a_issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    chk("lb_req", a_mem_req, 1'b1);
    chk("lb_ready_low", a_req_ready, 1'b0);
    chk("lb_addr", a_mem_addr, 32'h0000_1000);
    chk("lb_we_be", {a_mem_we, a_mem_be}, 5'b0_0000);
    chk("lb_no_rsp1", a_rsp_valid, 1'b0);
    a_gnt = 1'b1;
    tick();
    a_gnt = 1'b0;
    chk("lb_wait_req", a_mem_req, 1'b0);
    chk("lb_no_rsp2", a_rsp_valid, 1'b0);
    a_rvalid = 1'b1; a_rdata = 32'h80FF_FF12;
    tick();
    a_rvalid = 1'b0;
    chk("lb_rsp_valid", a_rsp_valid, 1'b1);
    chk("lb_rdata", a_rsp_rdata, 32'hFFFF_FF80);
    chk("lb_flags", {a_mis, a_fault}, 2'b00);
    chk("lb_resp_not_ready", a_req_ready, 1'b0);
    tick();
    chk("lb_pulse_end", a_rsp_valid, 1'b0);
    chk("lb_back_idle", a_req_ready, 1'b1);

    // sh at 0x2002, immediate gnt
    a_issue(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD);
    chk("sh_req", {a_mem_req, a_mem_we}, 2'b11);
    chk("sh_be", a_mem_be, 4'b1100);
    chk("sh_wdata", a_mem_wdata, 32'hABCD_0000);
    chk("sh_addr", a_mem_addr, 32'h0000_2000);
    a_gnt = 1'b1;
    tick();
    a_gnt = 1'b0;
    chk("sh_rsp_valid", a_rsp_valid, 1'b1);
    chk("sh_rdata_zero", a_rsp_rdata, 32'h0);
    chk("sh_mem_req_off", a_mem_req, 1'b0);
    tick();

    // sb at 0x3001 with grant held off two cycles: request stays stable
    a_issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_0055);
    tick(); tick();
    chk("sb_hold_req", a_mem_req, 1'b1);
    chk("sb_hold_be", a_mem_be, 4'b0010);
    chk("sb_hold_wdata", a_mem_wdata, 32'h0000_5500);
    chk("sb_hold_addr", a_mem_addr, 32'h0000_3000);
    a_gnt = 1'b1;
    tick();
    a_gnt = 1'b0;
    chk("sb_done", {a_rsp_valid, a_fault}, 2'b10);
    tick();

    // lw at 0x0006: misaligned, answered one cycle later without memory
    a_issue(1'b0, 3'b010, 32'h0000_0006, 32'h0);
    chk("lw_mis_valid", a_rsp_valid, 1'b1);
    chk("lw_mis_flags", {a_mis, a_fault}, 2'b10);
    chk("lw_mis_no_req", a_mem_req, 1'b0);
    tick();
    chk("lw_mis_pulse_end", a_rsp_valid, 1'b0);

    // ld (011) at 0x1 on 32-bit: illegal wins over misaligned
    a_issue(1'b0, 3'b011, 32'h0000_0001, 32'h0);
    chk("ld32_flags", {a_rsp_valid, a_mis, a_fault}, 3'b101);
    tick();

    // lwu (110) on 32-bit: illegal
    a_issue(1'b0, 3'b110, 32'h0000_0004, 32'h0);
    chk("lwu32_fault", {a_rsp_valid, a_mis, a_fault, a_mem_req}, 4'b1010);
    tick();

    // store with funct3 100: illegal
    a_issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);
    chk("st100_fault", {a_rsp_valid, a_fault}, 2'b11);
    tick();

    // Timeout in REQ: mem_req high for 4 cycles, then fault
    a_issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    chk("to_req_c1", a_mem_req, 1'b1);
    tick();
    chk("to_req_c2", a_mem_req, 1'b1);
    tick();
    chk("to_req_c3", a_mem_req, 1'b1);
    tick();
    chk("to_req_c4", {a_mem_req, a_rsp_valid}, 2'b10);
    tick();
    chk("to_fault", {a_rsp_valid, a_fault, a_mis}, 3'b110);
    chk("to_req_dropped", a_mem_req, 1'b0);
    chk("to_rdata_zero", a_rsp_rdata, 32'h0);
    tick();

    // lhu at 0x22: rvalid during REQ ignored; rvalid on the timeout cycle wins
    a_issue(1'b0, 3'b101, 32'h0000_0022, 32'h0);
    a_gnt = 1'b1; a_rvalid = 1'b1; a_rdata = 32'hDEAD_BEEF;
    tick();
    a_gnt = 1'b0; a_rvalid = 1'b0;
    chk("lhu_in_wait", {a_rsp_valid, a_mem_req}, 2'b00);
    tick(); tick(); tick();
    chk("lhu_still_wait", a_rsp_valid, 1'b0);
    a_rvalid = 1'b1; a_rdata = 32'h1234_5678;
    tick();
    a_rvalid = 1'b0;
    chk("lhu_rsp", {a_rsp_valid, a_fault, a_mis}, 3'b100);
    chk("lhu_rdata", a_rsp_rdata, 32'h0000_1234);
    tick();

    // 64-bit: lwu at 0x104
    b_issue(1'b0, 3'b110, 64'h0000_0000_0000_0104, 64'h0);
    chk("b_lwu_addr", b_mem_addr, 64'h0000_0000_0000_0100);
    b_gnt = 1'b1;
    tick();
    b_gnt = 1'b0;
    b_rvalid = 1'b1; b_rdata = 64'hF000_0001_0000_0000;
    tick();
    b_rvalid = 1'b0;
    chk("b_lwu_valid", {b_rsp_valid, b_fault, b_mis}, 3'b100);
    chk("b_lwu_rdata", b_rsp_rdata, 64'h0000_0000_F000_0001);
    tick();

    // 64-bit: lw at 0x104 sign-extends the same word
    b_issue(1'b0, 3'b010, 64'h0000_0000_0000_0104, 64'h0);
    b_gnt = 1'b1;
    tick();
    b_gnt = 1'b0;
    b_rvalid = 1'b1;
    tick();
    b_rvalid = 1'b0;
    chk("b_lw_rdata", b_rsp_rdata, 64'hFFFF_FFFF_F000_0001);
    tick();

    // 64-bit: sd at 0x8 is legal, full byte enables
    b_issue(1'b1, 3'b011, 64'h0000_0000_0000_0008, 64'h0123_4567_89AB_CDEF);
    chk("b_sd_be", b_mem_be, 8'hFF);
    chk("b_sd_wdata", b_mem_wdata, 64'h0123_4567_89AB_CDEF);
    b_gnt = 1'b1;
    tick();
    b_gnt = 1'b0;
    chk("b_sd_done", {b_rsp_valid, b_fault, b_mis}, 3'b100);
    tick();

    // 64-bit: ld at 0x14 is misaligned
    b_issue(1'b0, 3'b011, 64'h0000_0000_0000_0014, 64'h0);
    chk("b_ld_mis", {b_rsp_valid, b_mis, b_fault}, 3'b110);
    tick();

    // Reset pulse during WAIT aborts; later rvalid ignored
    a_issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    a_gnt = 1'b1;
    tick();
    a_gnt = 1'b0;
    chk("rw_in_wait", {a_mem_req, a_req_ready}, 2'b00);
    reset_n = 1'b0;
    #1;
    chk("rw_ready_async", a_req_ready, 1'b1);
    chk("rw_no_rsp_async", a_rsp_valid, 1'b0);
    #1;
    reset_n = 1'b1;
    a_rvalid = 1'b1; a_rdata = 32'hCAFE_F00D;
    tick();
    a_rvalid = 1'b0;
    chk("rw_no_rsp1", a_rsp_valid, 1'b0);
    chk("rw_ready1", a_req_ready, 1'b1);
    tick();
    chk("rw_no_rsp2", a_rsp_valid, 1'b0);
    chk("rw_rdata_zero", a_rsp_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
